// File: rtl/mem_serializer_pkg.sv
// Shared types and constants for the memory-side serializer of the 2-bit serial ALU.
package mem_serializer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_SHIFT = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam int REG_BITS_DEF = 8;
   localparam int NSHIFT_DEF   = 2;

   localparam logic [2:0] LAST_BEAT_PAIR = 3'd7;
   localparam logic [2:0] LAST_BEAT_BYTE = 3'd3;

   function automatic logic [2:0] last_beat(input logic pair);
      return pair ? LAST_BEAT_PAIR : LAST_BEAT_BYTE;
   endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Operand/result shift register: parallel load, LSB-first shift with insertion at the top,
// and a byte-swapped write view so a byte result lands in the low byte.
module serial_shift_reg #(
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic [2*REG_BITS-1:0]   load_data,
   input  logic                    shift_en,
   input  logic [NSHIFT-1:0]       shift_in,
   input  logic                    swap,
   output logic [2*REG_BITS-1:0]   sreg,
   output logic [2*REG_BITS-1:0]   wdata
);

   always_ff @(posedge clk) begin
      if (reset) begin
         sreg <= '0;
      end else if (load_en) begin
         sreg <= load_data;
      end else if (shift_en) begin
         sreg <= {shift_in, sreg[2*REG_BITS-1:NSHIFT]};
      end
   end

   // In byte mode the shifted result sits in the upper byte; swap it back down.
   assign wdata = swap ? {sreg[REG_BITS-1:0], sreg[2*REG_BITS-1:REG_BITS]} : sreg;

endmodule

// File: rtl/mem_serializer.sv
// Fetches a word, streams it to the serial ALU 2 bits per active cycle, captures the result
// and optionally writes it back. Define MEM_SERIALIZER_BYTE_EN to enable 8-bit transfers.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | memory read request outstanding
// SHIFT   | exchanging operand/result bits with the ALU
// WRITE   | memory write request outstanding
module mem_serializer
   import mem_serializer_pkg::*;
#(
   parameter int REG_BITS  = REG_BITS_DEF,
   parameter int NSHIFT    = NSHIFT_DEF,
   parameter int ADDR_BITS = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    load,
   input  logic                    store,
   input  logic                    pair,
   input  logic [ADDR_BITS-1:0]    addr,
   input  logic [2*REG_BITS-1:0]   init,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic                    mem_byte,
   output logic [ADDR_BITS-1:0]    mem_addr,
   output logic [2*REG_BITS-1:0]   mem_wdata,
   input  logic                    mem_ack,
   input  logic [2*REG_BITS-1:0]   mem_rdata,
   input  logic                    alu_active,
   output logic [NSHIFT-1:0]       alu_data_in,
   input  logic [NSHIFT-1:0]       alu_data_out,
   output logic                    ready,
   output logic                    busy,
   output logic                    done
);

   state_t                  state;
   logic                    pair_q;
   logic                    store_q;
   logic [2:0]              beat;
   logic                    pair_eff;
   logic                    load_en;
   logic                    shift_en;
   logic [2*REG_BITS-1:0]   load_data;
   logic [2*REG_BITS-1:0]   sreg;

`ifdef MEM_SERIALIZER_BYTE_EN
   assign pair_eff = pair;
`else
   // Every transfer is a full word; pair only feeds a constant-true term.
   assign pair_eff = pair | 1'b1;
`endif

   assign load_en   = ((state == S_IDLE) && start && !load) || ((state == S_READ) && mem_ack);
   assign load_data = (state == S_READ) ? mem_rdata : init;
   assign shift_en  = (state == S_SHIFT) && alu_active;

   assign alu_data_in = (state == S_SHIFT) ? sreg[NSHIFT-1:0] : '0;

   serial_shift_reg #(
      .REG_BITS (REG_BITS),
      .NSHIFT   (NSHIFT)
   ) u_sreg (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_data (load_data),
      .shift_en  (shift_en),
      .shift_in  (alu_data_out),
      .swap      (!pair_q),
      .sreg      (sreg),
      .wdata     (mem_wdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         pair_q   <= 1'b1;
         store_q  <= 1'b0;
         beat     <= 3'd0;
         mem_addr <= '0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         mem_byte <= 1'b0;
         ready    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  mem_addr <= addr;
                  pair_q   <= pair_eff;
                  store_q  <= store;
                  beat     <= 3'd0;
                  busy     <= 1'b1;
                  if (load) begin
                     state    <= S_READ;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_byte <= !pair_eff;
                  end else begin
                     state <= S_SHIFT;
                     ready <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (mem_ack) begin
                  state    <= S_SHIFT;
                  mem_req  <= 1'b0;
                  mem_byte <= 1'b0;
                  ready    <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (alu_active) begin
                  beat <= beat + 3'd1;
                  if (beat == last_beat(pair_q)) begin
                     ready <= 1'b0;
                     if (store_q) begin
                        state    <= S_WRITE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_byte <= !pair_q;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            S_WRITE: begin
               if (mem_ack) begin
                  state    <= S_IDLE;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  mem_byte <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
